// File: rtl/ar_id_remap_allocator_pkg.sv
// Shared sizing helpers and uid packing convention for the AR ID remap path.
// The r_id_ordering_unit imports the same package so both sides agree on uid = {row, col}.
package ar_id_remap_allocator_pkg;

    localparam int unsigned MAX_OUTSTANDING = 16;
    localparam int unsigned ID_WIDTH        = 4;

    // Index width that never collapses to zero bits for single-entry dimensions.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ROW_W = idx_w(MAX_OUTSTANDING);
    localparam int unsigned COL_W = idx_w(MAX_OUTSTANDING);
    localparam int unsigned UID_W = ROW_W + COL_W;

    // uid = {row, col}; callers truncate the result to their own UID width.
    function automatic logic [31:0] uid_pack(input int unsigned row, input int unsigned col,
                                             input int unsigned col_w);
        return 32'((row << col_w) | col);
    endfunction

    function automatic int unsigned uid_row(input logic [31:0] uid, input int unsigned col_w);
        return uid >> col_w;
    endfunction

    function automatic int unsigned uid_col(input logic [31:0] uid, input int unsigned col_w);
        return uid & ((32'd1 << col_w) - 32'd1);
    endfunction

endpackage

// File: rtl/ar_id_remap_allocator_if.sv
// Valid/ready AR channel bundle; ID_W carries the original ID or the remapped uid.
interface ar_id_remap_allocator_if #(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned PAYLOAD_W = 64
);
    logic                 valid;
    logic                 ready;
    logic [ID_W-1:0]      id;
    logic [PAYLOAD_W-1:0] payload;

    modport master (output valid, output id, output payload, input ready);
    modport slave  (input valid, input id, input payload, output ready);
endinterface

// File: rtl/ar_uid_reg_slice.sv
// One-entry forward register slice holding the remapped request for the slave side.
module ar_uid_reg_slice #(
    parameter int unsigned UID_W     = 8,
    parameter int unsigned PAYLOAD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [UID_W-1:0]     in_uid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [UID_W-1:0]     out_uid,
    output logic [PAYLOAD_W-1:0] out_payload
);
    logic                 valid_q;
    logic [UID_W-1:0]     uid_q;
    logic [PAYLOAD_W-1:0] payload_q;

    assign in_ready    = !valid_q || out_ready;
    assign out_valid   = valid_q;
    assign out_uid     = uid_q;
    assign out_payload = payload_q;

    // Load a new beat when empty or draining; hold contents while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            uid_q     <= '0;
            payload_q <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                uid_q     <= in_uid;
                payload_q <= in_payload;
            end
        end
    end
endmodule

// File: rtl/ar_id_remap_allocator.sv
// Binds original AR IDs to table rows and hands out per-row column slots as unique uids.
module ar_id_remap_allocator #(
    parameter int unsigned ID_WIDTH        = ar_id_remap_allocator_pkg::ID_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = ar_id_remap_allocator_pkg::MAX_OUTSTANDING,
    parameter int unsigned NUM_ROWS        = MAX_OUTSTANDING,
    parameter int unsigned NUM_COLS        = MAX_OUTSTANDING,
    parameter int unsigned PAYLOAD_W       = 64,
    localparam int unsigned ROW_W          = ar_id_remap_allocator_pkg::idx_w(NUM_ROWS),
    localparam int unsigned COL_W          = ar_id_remap_allocator_pkg::idx_w(NUM_COLS),
    localparam int unsigned UID_W          = ROW_W + COL_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ar_id_remap_allocator_if.slave ar_in,
    ar_id_remap_allocator_if.master ar_out,
    input  logic                   free_req,
    input  logic [UID_W-1:0]       free_uid,
    input  logic [UID_W-1:0]       lookup_uid,
    output logic [ID_WIDTH-1:0]    lookup_id,
    output logic                   err_free
);
    import ar_id_remap_allocator_pkg::*;

    localparam int unsigned CNT_W = $clog2(NUM_COLS + 1);
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(NUM_COLS);

    logic [NUM_ROWS-1:0] bound_q, bound_d;
    logic [ID_WIDTH-1:0] bound_id_q [NUM_ROWS];
    logic [ID_WIDTH-1:0] bound_id_d [NUM_ROWS];
    logic [COL_W-1:0]    alloc_ptr_q [NUM_ROWS];
    logic [COL_W-1:0]    alloc_ptr_d [NUM_ROWS];
    logic [CNT_W-1:0]    count_q [NUM_ROWS];
    logic [CNT_W-1:0]    count_d [NUM_ROWS];
    logic                err_free_q, err_free_d;

    logic             hit, has_free, acceptable, alloc, slice_ready, free_ok;
    logic [ROW_W-1:0] hit_row, unbound_row, alloc_row, free_row, lookup_row;
    logic [UID_W-1:0] alloc_uid;

    // Find the row already bound to this ID and the lowest-index unbound row.
    always_comb begin
        hit         = 1'b0;
        hit_row     = '0;
        has_free    = 1'b0;
        unbound_row = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (bound_q[r] && (bound_id_q[r] == ar_in.id) && !hit) begin
                hit     = 1'b1;
                hit_row = ROW_W'(r);
            end
            if (!bound_q[r] && !has_free) begin
                has_free    = 1'b1;
                unbound_row = ROW_W'(r);
            end
        end
    end

    assign alloc_row   = hit ? hit_row : unbound_row;
    assign acceptable  = hit ? (count_q[hit_row] < CntFull) : has_free;
    assign ar_in.ready = acceptable && slice_ready;
    assign alloc       = ar_in.valid && ar_in.ready;
    assign alloc_uid   = UID_W'(uid_pack(32'(alloc_row), 32'(alloc_ptr_q[alloc_row]), COL_W));

    assign free_row = ROW_W'(uid_row(32'(free_uid), COL_W));
    assign free_ok  = free_req && (int'(free_row) < NUM_ROWS) && bound_q[free_row]
                      && (count_q[free_row] != '0);

    assign lookup_row = ROW_W'(uid_row(32'(lookup_uid), COL_W));
    assign lookup_id  = bound_id_q[lookup_row];
    assign err_free   = err_free_q;

    // Row table update; the freed row is still bound this cycle, so a miss never picks it.
    always_comb begin
        bound_d     = bound_q;
        bound_id_d  = bound_id_q;
        alloc_ptr_d = alloc_ptr_q;
        count_d     = count_q;
        err_free_d  = err_free_q || (free_req && !free_ok);
        if (alloc) begin
            bound_d[alloc_row]     = 1'b1;
            bound_id_d[alloc_row]  = ar_in.id;
            alloc_ptr_d[alloc_row] = alloc_ptr_q[alloc_row] + 1'b1;
            count_d[alloc_row]     = count_q[alloc_row] + 1'b1;
        end
        // Applied on top of any same-row increment, so alloc+free leaves count unchanged.
        if (free_ok) begin
            count_d[free_row] = count_d[free_row] - 1'b1;
            if (count_d[free_row] == '0) begin
                bound_d[free_row] = 1'b0;
            end
        end
    end

    // Row table state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bound_q     <= '0;
            bound_id_q  <= '{default: '0};
            alloc_ptr_q <= '{default: '0};
            count_q     <= '{default: '0};
            err_free_q  <= 1'b0;
        end else begin
            bound_q     <= bound_d;
            bound_id_q  <= bound_id_d;
            alloc_ptr_q <= alloc_ptr_d;
            count_q     <= count_d;
            err_free_q  <= err_free_d;
        end
    end

    ar_uid_reg_slice #(
        .UID_W     (UID_W),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_slice (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (alloc),
        .in_ready    (slice_ready),
        .in_uid      (alloc_uid),
        .in_payload  (ar_in.payload),
        .out_valid   (ar_out.valid),
        .out_ready   (ar_out.ready),
        .out_uid     (ar_out.id),
        .out_payload (ar_out.payload)
    );
endmodule

// File: tb/tb_ar_id_remap_allocator.sv
// Bench for ar_id_remap_allocator: constant vector table, hand sequences, random vs model.
module tb_ar_id_remap_allocator;
    import ar_id_remap_allocator_pkg::*;

    localparam int unsigned IDW = 5;
    localparam int unsigned NR  = 16;
    localparam int unsigned NC  = 16;
    localparam int unsigned PW  = 64;
    localparam int unsigned UW  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ar_id_remap_allocator_if #(.ID_W(IDW), .PAYLOAD_W(PW)) in_if ();
    ar_id_remap_allocator_if #(.ID_W(UW), .PAYLOAD_W(PW)) out_if ();

    logic           free_req;
    logic [UW-1:0]  free_uid;
    logic [UW-1:0]  lookup_uid;
    logic [IDW-1:0] lookup_id;
    logic           err_free;

    ar_id_remap_allocator #(
        .ID_WIDTH        (IDW),
        .MAX_OUTSTANDING (16),
        .PAYLOAD_W       (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ar_in      (in_if),
        .ar_out     (out_if),
        .free_req   (free_req),
        .free_uid   (free_uid),
        .lookup_uid (lookup_uid),
        .lookup_id  (lookup_id),
        .err_free   (err_free)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [IDW-1:0] id, input logic [63:0] pl,
                         input logic ordy, input logic fr, input logic [UW-1:0] fu,
                         input logic [UW-1:0] lu);
        in_if.valid   = v;
        in_if.id      = id;
        in_if.payload = pl;
        out_if.ready  = ordy;
        free_req      = fr;
        free_uid      = fu;
        lookup_uid    = lu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: rows as plain counters ----------------
    bit             m_bound [NR];
    logic [IDW-1:0] m_id    [NR];
    int             m_ptr   [NR];
    int             m_cnt   [NR];
    bit             m_err;
    bit             m_ov;
    logic [UW-1:0]  m_uid;
    logic [63:0]    m_pl;
    logic [UW-1:0]  issued [$];

    task automatic model_clear();
        for (int r = 0; r < NR; r++) begin
            m_bound[r] = 0; m_id[r] = '0; m_ptr[r] = 0; m_cnt[r] = 0;
        end
        m_err = 0; m_ov = 0; m_uid = '0; m_pl = '0;
        issued.delete();
    endtask

    task automatic model_cycle(input logic v, input logic [IDW-1:0] id, input logic [63:0] pl,
                               input logic ordy, input logic fr, input logic [UW-1:0] fu,
                               input logic [UW-1:0] lu);
        int  hr = -1;
        int  ur = -1;
        int  row;
        int  frow;
        bit  ok, e_rdy, take, fok;
        for (int r = 0; r < NR; r++) if (m_bound[r] && m_id[r] == id) hr = r;
        for (int r = NR - 1; r >= 0; r--) if (!m_bound[r]) ur = r;
        ok    = (hr >= 0) ? (m_cnt[hr] < NC) : (ur >= 0);
        e_rdy = ok && (!m_ov || ordy);
        chk("rnd_ready", 64'(in_if.ready), 64'(e_rdy));
        chk("rnd_out_valid", 64'(out_if.valid), 64'(m_ov));
        if (m_ov) begin
            chk("rnd_out_uid", 64'(out_if.id), 64'(m_uid));
            chk("rnd_out_payload", out_if.payload, m_pl);
        end
        chk("rnd_lookup", 64'(lookup_id), 64'(m_id[int'(lu) / NC]));
        chk("rnd_err_free", 64'(err_free), 64'(m_err));
        // state advance at the clock edge
        take = v && e_rdy;
        row  = (hr >= 0) ? hr : ur;
        frow = int'(fu) / NC;
        fok  = fr && m_bound[frow] && m_cnt[frow] > 0;
        if (fr && !fok) m_err = 1;
        if (take) begin
            m_bound[row] = 1;
            m_id[row]    = id;
            m_uid        = UW'(row * NC + m_ptr[row]);
            m_pl         = pl;
            m_ptr[row]   = (m_ptr[row] + 1) % NC;
            m_cnt[row]   = m_cnt[row] + 1;
            issued.push_back(m_uid);
        end
        if (fok) begin
            m_cnt[frow] = m_cnt[frow] - 1;
            if (m_cnt[frow] == 0) m_bound[frow] = 0;
        end
        if (take) m_ov = 1;
        else if (ordy) m_ov = 0;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    // ---------------- constant vector table (out_ready held at 1) ----------------
    typedef struct {
        logic           v;
        logic [IDW-1:0] id;
        logic           fr;
        logic [UW-1:0]  fu;
        logic [UW-1:0]  lu;
        logic           e_rdy;
        logic           e_ov;
        logic [UW-1:0]  e_uid;
        logic [IDW-1:0] e_lid;
        logic           e_err;
    } vec_t;

    function automatic vec_t mk(input logic v, input int id, input logic fr, input int fu,
                                input int lu, input logic e_rdy, input logic e_ov,
                                input int e_uid, input int e_lid, input logic e_err);
        vec_t t;
        t.v = v; t.id = IDW'(id); t.fr = fr; t.fu = UW'(fu); t.lu = UW'(lu);
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_uid = UW'(e_uid); t.e_lid = IDW'(e_lid);
        t.e_err = e_err;
        return t;
    endfunction

    vec_t tbl [13];

    initial begin
        logic [63:0] p0, p1;
        logic        rv, ro, rf;
        logic [IDW-1:0] rid;
        logic [UW-1:0]  rfu, rlu;
        logic [63:0]    rpl;

        tbl[0]  = mk(1, 3, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0);
        tbl[1]  = mk(1, 3, 0, 8'h00, 8'h00, 1, 1, 8'h00, 3, 0);
        tbl[2]  = mk(1, 5, 0, 8'h00, 8'h00, 1, 1, 8'h01, 3, 0);
        tbl[3]  = mk(0, 0, 0, 8'h00, 8'h15, 1, 1, 8'h10, 5, 0);
        tbl[4]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 3, 0);
        tbl[5]  = mk(1, 7, 0, 8'h00, 8'h00, 1, 0, 8'h00, 3, 0);
        tbl[6]  = mk(1, 7, 1, 8'h20, 8'h00, 1, 1, 8'h20, 3, 0);  // alloc+free row 2
        tbl[7]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h21, 3, 0);
        tbl[8]  = mk(0, 0, 1, 8'h21, 8'h00, 1, 0, 8'h00, 3, 0);  // last free row 2
        tbl[9]  = mk(0, 0, 1, 8'h70, 8'h20, 1, 0, 8'h00, 7, 0);  // free unbound row 7
        tbl[10] = mk(1, 9, 0, 8'h00, 8'h00, 1, 0, 8'h00, 3, 1);  // rebinds row 2 at col 2
        tbl[11] = mk(0, 0, 0, 8'h00, 8'h22, 1, 1, 8'h22, 9, 1);
        tbl[12] = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 3, 1);

        drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        do_reset();
        #1;
        chk("rst_out_valid", 64'(out_if.valid), 64'd0);
        chk("rst_out_uid", 64'(out_if.id), 64'd0);
        chk("rst_out_payload", out_if.payload, 64'd0);
        chk("rst_err_free", 64'(err_free), 64'd0);
        chk("rst_in_ready", 64'(in_if.ready), 64'd1);
        #1;

        // table
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].id, 64'(100 + i), 1'b1, tbl[i].fr, tbl[i].fu, tbl[i].lu);
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(in_if.ready), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_valid", i), 64'(out_if.valid), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_uid", i), 64'(out_if.id), 64'(tbl[i].e_uid));
                chk($sformatf("tbl%0d_payload", i), out_if.payload, 64'(100 + i - 1));
            end
            chk($sformatf("tbl%0d_lookup", i), 64'(lookup_id), 64'(tbl[i].e_lid));
            chk($sformatf("tbl%0d_err", i), 64'(err_free), 64'(tbl[i].e_err));
            tick();
        end

        // column wrap: 16 outstanding on one row stalls until slot {0,0} is freed
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 5'd3, 64'(k), 1'b1, 1'b0, '0, '0);
            #1; chk("wrap_fill_ready", 64'(in_if.ready), 64'd1); tick();
        end
        drive(1'b1, 5'd3, 64'd99, 1'b1, 1'b0, '0, '0);
        #1; chk("wrap_full_stall", 64'(in_if.ready), 64'd0);
        chk("wrap_last_uid", 64'(out_if.id), 64'h0f); tick();
        drive(1'b1, 5'd3, 64'd99, 1'b1, 1'b1, 8'h00, '0);
        #1; chk("wrap_free_cycle_stall", 64'(in_if.ready), 64'd0); tick();
        drive(1'b1, 5'd3, 64'd99, 1'b1, 1'b0, '0, '0);
        #1; chk("wrap_resume_ready", 64'(in_if.ready), 64'd1); tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        #1; chk("wrap_out_valid", 64'(out_if.valid), 64'd1);
        chk("wrap_uid", 64'(out_if.id), 64'h00); tick();

        // all rows bound: a new ID waits for a row, then reuses its live alloc_ptr
        do_reset();
        for (int r = 0; r < 16; r++) begin
            drive(1'b1, IDW'(16 + r), 64'(r), 1'b1, 1'b0, '0, '0);
            #1; chk("bind_ready", 64'(in_if.ready), 64'd1); tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 5'd20, 64'(k), 1'b1, 1'b0, '0, '0);
            #1; chk("row4_extra_ready", 64'(in_if.ready), 64'd1); tick();
        end
        drive(1'b1, 5'd9, 64'd9, 1'b1, 1'b0, '0, '0);
        #1; chk("miss_stall", 64'(in_if.ready), 64'd0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd9, 64'd9, 1'b1, 1'b1, UW'(8'h40 + k), '0);
            #1; chk("miss_stall_freeing", 64'(in_if.ready), 64'd0); tick();
        end
        drive(1'b1, 5'd9, 64'd9, 1'b1, 1'b0, '0, '0);
        #1; chk("rebind_ready", 64'(in_if.ready), 64'd1); tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0, '0, 8'h43);
        #1; chk("rebind_valid", 64'(out_if.valid), 64'd1);
        chk("rebind_uid", 64'(out_if.id), 64'h43);
        chk("rebind_lookup", 64'(lookup_id), 64'd9); tick();

        // downstream backpressure holds the slice stable and blocks upstream
        do_reset();
        p0 = 64'hA0A0_0000_0000_00A0;
        p1 = 64'hB1B1_0000_0000_00B1;
        drive(1'b1, 5'd2, p0, 1'b1, 1'b0, '0, '0);
        #1; chk("bp_first_ready", 64'(in_if.ready), 64'd1); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd2, p1, 1'b0, 1'b0, '0, '0);
            #1;
            chk("bp_ready_low", 64'(in_if.ready), 64'd0);
            chk("bp_valid_held", 64'(out_if.valid), 64'd1);
            chk("bp_uid_held", 64'(out_if.id), 64'h00);
            chk("bp_payload_held", out_if.payload, p0);
            tick();
        end
        drive(1'b1, 5'd2, p1, 1'b1, 1'b0, '0, '0);
        #1; chk("bp_release_ready", 64'(in_if.ready), 64'd1);
        chk("bp_release_uid", 64'(out_if.id), 64'h00); tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        #1; chk("bp_second_valid", 64'(out_if.valid), 64'd1);
        chk("bp_second_uid", 64'(out_if.id), 64'h01);
        chk("bp_second_payload", out_if.payload, p1); tick();
        #1; chk("bp_drained", 64'(out_if.valid), 64'd0);
        @(posedge clk); #1;

        // asynchronous reset while a beat is held on the output
        drive(1'b1, 5'd4, 64'h44, 1'b0, 1'b0, '0, '0);
        #1; tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        #1; chk("midrst_valid_before", 64'(out_if.valid), 64'd1);
        #1; rst_n = 1'b0;
        #1; chk("midrst_valid_dropped", 64'(out_if.valid), 64'd0);
        chk("midrst_err_clear", 64'(err_free), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        drive(1'b1, 5'd6, 64'h66, 1'b1, 1'b0, '0, '0);
        #1; chk("midrst_ready", 64'(in_if.ready), 64'd1); tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        #1; chk("midrst_next_valid", 64'(out_if.valid), 64'd1);
        chk("midrst_next_uid", 64'(out_if.id), 64'h00); tick();

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rv  = ($urandom_range(0, 3) != 0);
            rid = ($urandom_range(0, 9) == 0) ? IDW'($urandom_range(0, 31))
                                               : IDW'($urandom_range(0, 5));
            rpl = {$urandom(), $urandom()};
            ro  = ($urandom_range(0, 3) != 0);
            rf  = 1'b0;
            rfu = '0;
            if (issued.size() > 0 && $urandom_range(0, 1) == 1) begin
                rf  = 1'b1;
                rfu = issued.pop_front();
            end else if ($urandom_range(0, 49) == 0) begin
                rf  = 1'b1;
                rfu = UW'($urandom_range(0, 255));
            end
            rlu = UW'($urandom_range(0, 255));
            drive(rv, rid, rpl, ro, rf, rfu, rlu);
            #1;
            model_cycle(rv, rid, rpl, ro, rf, rfu, rlu);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ar_id_remap_allocator.md
AR_ID_REMAP_ALLOCATOR -- requirements
Module: ar_id_remap_allocator

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4: original AXI ID width.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16: sizing base.
REQ-003 SHALL have parameter NUM_ROWS, default MAX_OUTSTANDING: number of concurrently bound original IDs.
REQ-004 SHALL have parameter NUM_COLS, default MAX_OUTSTANDING: outstanding slots per row; power of two.
REQ-005 SHALL have parameter PAYLOAD_W, default 64: opaque AR payload (addr/len/size/burst) width.
REQ-006 SHALL have derived UID_W = $clog2(NUM_ROWS)+$clog2(NUM_COLS); uid = {row,col}.
REQ-007 clk  in  1  single clock, all logic rising-edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 ar_in_valid / ar_in_ready  in / out  1 / 1  upstream request handshake.
REQ-010 ar_in_id / ar_in_payload  in  ID_WIDTH / PAYLOAD_W  original ID and payload.
REQ-011 ar_out_valid / ar_out_ready  out / in  1 / 1  downstream (slave-side) handshake.
REQ-012 ar_out_uid / ar_out_payload  out  UID_W / PAYLOAD_W  remapped request.
REQ-013 free_req / free_uid  in  1 / UID_W  release from r_id_ordering_unit after in-order delivery.
REQ-014 lookup_uid / lookup_id  in / out  UID_W / ID_WIDTH  combinational uid->original-ID restore.
REQ-015 err_free  out  1  sticky: free of unbound row or zero-count row.

Function
REQ-016 Per row state SHALL be: bound bit, bound_id, alloc_ptr (COL_W), count (0..NUM_COLS).
REQ-017 Allocation SHALL hit the bound row whose bound_id == ar_in_id; else take the lowest-index unbound row and bind it.
REQ-018 Allocated col SHALL be alloc_ptr[row]; alloc_ptr increments by 1, wrapping NUM_COLS-1 -> 0.
REQ-019 alloc_ptr SHALL NOT reset on row unbind (must stay aligned with the ordering unit's per-row release_idx); only rst_n clears it.
REQ-020 A request SHALL be acceptable iff (hit row with count < NUM_COLS) or (miss and an unbound row exists).
REQ-021 ar_in_ready SHALL = acceptable && (!ar_out_valid || ar_out_ready); combinational, no dependency on ar_in_ready itself.
REQ-022 Output SHALL be a one-entry register slice: accepted request appears on ar_out the next cycle (latency 1); back-to-back throughput 1/cycle when ar_out_ready=1.
REQ-023 ar_out_valid/uid/payload SHALL hold stable while ar_out_valid && !ar_out_ready.
REQ-024 free_req SHALL decrement count[free row]; count reaching 0 SHALL clear bound in the same edge.
REQ-025 Simultaneous alloc and free on the same row SHALL leave count unchanged and row bound.
REQ-026 Free and a miss-allocation in the same cycle SHALL NOT reuse the row being freed that cycle.
REQ-027 Free on unbound or zero-count row SHALL be ignored and set err_free.
REQ-028 lookup_id SHALL = bound_id[lookup_uid row] (value retained after unbind until rebind).

Reset
REQ-029 On rst_n low: ar_out_valid=0, ar_out_uid=0, ar_out_payload=0, all bound=0, bound_id=0, alloc_ptr=0, count=0, err_free=0; ar_in_ready follows REQ-021 (1 after reset).
REQ-030 Reset mid-transfer SHALL drop the in-flight output beat; no partial state survives.

Structure
REQ-031 ID_WIDTH, UID_W, ROW_W, COL_W helpers and the uid pack/unpack convention SHALL live in the shared package used by r_id_ordering_unit.
REQ-032 The output register slice SHALL be a sub-module ar_uid_reg_slice; row table stays in the top module.

Verification
REQ-033 Reset, ar_in id=3 -> next cycle ar_out_uid={row0,col0}; second id=3 -> {0,1}; id=5 -> {1,0}.
REQ-034 16 id=3 requests with ar_out_ready=1, no frees -> 17th stalls (ar_in_ready=0) until free_uid={0,0}, then issues {0,0} (wrap).
REQ-035 Bind all 16 rows with distinct IDs, new id=9 -> stalls; free last outstanding of row 4 -> id=9 binds row 4, col = row 4's alloc_ptr (not 0).
REQ-036 ar_out_ready=0 for 3 cycles -> ar_out stable, ar_in_ready=0, no request lost or duplicated.
REQ-037 Same-cycle alloc and free on row 2 (count=1) -> count stays 1, row stays bound; free to unbound row 7 -> err_free=1, state unchanged.
REQ-038 Assert rst_n low while ar_out_valid=1 -> ar_out_valid=0 immediately, next request gets {0,0}.
